// File: rtl/brent_kung_pipe.sv
// rtl/brent_kung_pipe.sv - three-stage Brent-Kung prefix adder/subtractor with valid/ready flow control
module brent_kung_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             ovf
);
  localparam int LOG = $clog2(WIDTH);

  // Up-sweep: after level l, bit i with (i+1) a multiple of 2^(l+1) holds the group g/p of that span.
  function automatic logic [2*WIDTH-1:0] up_sweep(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    g = g_in;
    p = p_in;
    for (int l = 0; l < LOG; l++) begin
      for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
        g[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p[i] = p[i] & p[i - (1 << l)];
      end
    end
    return {p, g};
  endfunction

  // Down-sweep fills the remaining prefixes; p is only read at group positions left by the up-sweep.
  function automatic logic [WIDTH-1:0] down_sweep(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g;
    g = g_in;
    for (int l = LOG - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
        g[i] = g[i] | (p_in[i] & g[i - (1 << l)]);
      end
    end
    return g;
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_fold;
  logic [WIDTH-1:0] g_up;
  logic [WIDTH-1:0] p_up;
  logic [WIDTH-1:0] g_pre;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic [WIDTH-1:0] p1_q, p1_d;
  logic             cin1_q, cin1_d;
  logic             am1_q, am1_d;
  logic             bm1_q, bm1_d;

  logic             v2_q, v2_d;
  logic [WIDTH-1:0] g2_q, g2_d;
  logic [WIDTH-1:0] p2_q, p2_d;
  logic [WIDTH-1:0] pb2_q, pb2_d;
  logic             cin2_q, cin2_d;
  logic             am2_q, am2_d;
  logic             bm2_q, bm2_d;

  logic             v3_q, v3_d;
  logic [WIDTH:0]   out_q, out_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    adv    = !v3_q || out_ready;
    b_eff  = sub ? ~in2 : in2;

    // Carry-in is the generate of bit -1, folded into bit 0 before the tree.
    g_fold    = g1_q;
    g_fold[0] = g1_q[0] | (p1_q[0] & cin1_q);
    {p_up, g_up} = up_sweep(g_fold, p1_q);

    g_pre = down_sweep(g2_q, p2_q);
    carry = {g_pre[WIDTH-2:0], cin2_q};
    sum   = pb2_q ^ carry;

    v1_d   = v1_q;
    g1_d   = g1_q;
    p1_d   = p1_q;
    cin1_d = cin1_q;
    am1_d  = am1_q;
    bm1_d  = bm1_q;
    v2_d   = v2_q;
    g2_d   = g2_q;
    p2_d   = p2_q;
    pb2_d  = pb2_q;
    cin2_d = cin2_q;
    am2_d  = am2_q;
    bm2_d  = bm2_q;
    v3_d   = v3_q;
    out_d  = out_q;
    ovf_d  = ovf_q;

    if (adv) begin
      v1_d   = in_valid;
      g1_d   = in1 & b_eff;
      p1_d   = in1 ^ b_eff;
      cin1_d = sub ? !c0 : c0;
      am1_d  = in1[WIDTH-1];
      bm1_d  = b_eff[WIDTH-1];

      v2_d   = v1_q;
      g2_d   = g_up;
      p2_d   = p_up;
      pb2_d  = p1_q;
      cin2_d = cin1_q;
      am2_d  = am1_q;
      bm2_d  = bm1_q;

      v3_d   = v2_q;
      out_d  = {g_pre[WIDTH-1], sum};
      ovf_d  = (am2_q == bm2_q) && (sum[WIDTH-1] != am2_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      g1_q   <= '0;
      p1_q   <= '0;
      cin1_q <= 1'b0;
      am1_q  <= 1'b0;
      bm1_q  <= 1'b0;
      v2_q   <= 1'b0;
      g2_q   <= '0;
      p2_q   <= '0;
      pb2_q  <= '0;
      cin2_q <= 1'b0;
      am2_q  <= 1'b0;
      bm2_q  <= 1'b0;
      v3_q   <= 1'b0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      g1_q   <= g1_d;
      p1_q   <= p1_d;
      cin1_q <= cin1_d;
      am1_q  <= am1_d;
      bm1_q  <= bm1_d;
      v2_q   <= v2_d;
      g2_q   <= g2_d;
      p2_q   <= p2_d;
      pb2_q  <= pb2_d;
      cin2_q <= cin2_d;
      am2_q  <= am2_d;
      bm2_q  <= bm2_d;
      v3_q   <= v3_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_brent_kung_pipe.sv
// tb/tb_brent_kung_pipe.sv - directed and randomised checks of brent_kung_pipe at WIDTH 8, 32 and 64
module tb_brent_kung_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, c0 = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, ovf;
  logic [31:0] in1 = '0, in2 = '0;
  logic [32:0] out;

  logic        in_valid8 = 1'b0, c08 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b1;
  logic        in_ready8, out_valid8, ovf8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [8:0]  out8;

  logic        in_valid64 = 1'b0, c064 = 1'b0, sub64 = 1'b0, out_ready64 = 1'b1;
  logic        in_ready64, out_valid64, ovf64;
  logic [63:0] a64 = '0, b64 = '0;
  logic [64:0] out64;

  int errors = 0;
  int checks = 0;
  logic [65:0] q32[$];
  logic [65:0] q8[$];
  logic [65:0] q64[$];

  brent_kung_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .c0(c0), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf));

  brent_kung_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in1(a8), .in2(b8),
    .c0(c08), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .out(out8), .ovf(ovf8));

  brent_kung_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .in1(a64), .in2(b64),
    .c0(c064), .sub(sub64), .out_valid(out_valid64), .out_ready(out_ready64), .out(out64), .ovf(ovf64));

  // Reference: {ovf, carry, sum zero-extended to 64 bits}, computed as a wide integer sum.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sb);
    logic [63:0] mask, am, bm;
    logic [64:0] s;
    logic        cin;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (sb ? ~b : b) & mask;
    cin  = sb ? !ci : ci;
    s    = {1'b0, am} + {1'b0, bm} + {64'd0, cin};
    return {(am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]), s[w], s[63:0] & mask};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in1 = 32'h1; in2 = 32'h1; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 33'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_state: valid=%b out=%h ovf=%b expected 0/0/0", out_valid, out, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid8 !== 1'b0 || out8 !== 9'd0 || out_valid64 !== 1'b0 || out64 !== 65'd0) begin
      errors++; $display("FAIL reset_widths: v8=%b o8=%h v64=%b o64=%h expected zeros", out_valid8, out8, out_valid64, out64);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_ignored: out_valid=%b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    in_valid = 1'b1; in1 = 32'hFFFF_FFFF; in2 = 32'h0; c0 = 1'b1; sub = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL lat_in_ready: got %b expected 1", in_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (k == 3) begin
        if (out_valid !== 1'b1 || out !== 33'h1_0000_0000 || ovf !== 1'b0) begin
          errors++; $display("FAIL lat_result: valid=%b out=%h ovf=%b expected 1/100000000/0", out_valid, out, ovf);
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL lat_cycle%0d: out_valid=%b expected 0", k, out_valid);
      end
    end
  endtask

  task automatic test_subtract();
    logic [31:0] va[4];
    logic [31:0] vb[4];
    logic        vc[4];
    logic        vs[4];
    logic [33:0] ve[4];
    va = '{32'h8000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000};
    vb = '{32'h0000_0001, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0000};
    vc = '{1'b0, 1'b1, 1'b1, 1'b1};
    vs = '{1'b1, 1'b1, 1'b0, 1'b1};
    ve = '{{1'b1, 33'h1_7FFF_FFFF}, {1'b0, 33'h0_FFFF_FFFD}, {1'b0, 33'h1_FFFF_FFFF}, {1'b0, 33'h0_FFFF_FFFF}};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) begin
        in_valid = 1'b1; in1 = va[k]; in2 = vb[k]; c0 = vc[k]; sub = vs[k];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || {ovf, out} !== ve[k-3]) begin
          errors++; $display("FAIL sub_vec%0d: valid=%b ovf/out=%h expected %h", k - 3, out_valid, {ovf, out}, ve[k-3]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    in_valid = 1'b1; in1 = 32'h1234_5678; in2 = 32'h1111_1111; c0 = 1'b0; sub = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in1 = 32'h0000_FFFF; in2 = 32'h0000_0001;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out !== 33'h0_2345_6789) begin
      errors++; $display("FAIL mid_pre: valid=%b out=%h expected 1/023456789", out_valid, out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 33'd0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: valid=%b out=%h ovf=%b rdy=%b expected 0/0/0/1", out_valid, out, ovf, in_ready);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL mid_stale: out_valid=%b out=%h expected no result", out_valid, out);
      end
    end
  endtask

  task automatic test_backpressure();
    int          sent, got, k;
    logic [32:0] held;
    logic        hovf;
    logic [65:0] exp_v;
    sent = 0; got = 0; k = 0; held = '0; hovf = 1'b0;
    q32.delete();
    while (got < 10 && k < 60) begin
      @(negedge clk);
      in_valid  = (sent < 10);
      in1       = 32'(sent + 1) * 32'h1111_1111;
      in2       = 32'h0F0F_0F0F + 32'(sent);
      c0        = (sent % 2) == 1;
      sub       = ((sent / 2) % 2) == 1;
      out_ready = !(k >= 5 && k <= 8);
      #1;
      if (k >= 5 && k <= 8) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", k, in_ready);
        end
        if (k == 5) begin
          held = out; hovf = ovf;
        end else begin
          checks++;
          if (out !== held || ovf !== hovf || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: cycle %0d out=%h ovf=%b expected %h/%b", k, out, ovf, held, hovf);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q32.size() == 0) begin
          errors++; $display("FAIL bp_extra: out=%h expected no result", out);
        end else begin
          exp_v = q32.pop_front();
          if ({ovf, out[32], 32'd0, out[31:0]} !== exp_v) begin
            errors++; $display("FAIL bp_order: result %0d got %h expected %h", got, {ovf, out[32], 32'd0, out[31:0]}, exp_v);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q32.push_back(model(32, {32'd0, in1}, {32'd0, in2}, c0, sub));
        sent++;
      end
      k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 10 || q32.size() != 0) begin
      errors++; $display("FAIL bp_count: delivered %0d pending %0d expected 10/0", got, q32.size());
    end
  endtask

  task automatic test_width8();
    logic [7:0] va[4];
    logic [7:0] vb[4];
    logic       vc[4];
    logic       vs[4];
    logic [9:0] ve[4];
    va = '{8'h7F, 8'hFF, 8'h00, 8'h80};
    vb = '{8'h01, 8'h00, 8'h01, 8'h01};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1};
    ve = '{{1'b1, 9'h080}, {1'b0, 9'h100}, {1'b0, 9'h0FF}, {1'b1, 9'h17F}};
    out_ready8 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) begin
        in_valid8 = 1'b1; a8 = va[k]; b8 = vb[k]; c08 = vc[k]; sub8 = vs[k];
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      if (k >= 3) begin
        checks++;
        if (out_valid8 !== 1'b1 || {ovf8, out8} !== ve[k-3]) begin
          errors++; $display("FAIL w8_vec%0d: valid=%b ovf/out=%h expected %h", k - 3, out_valid8, {ovf8, out8}, ve[k-3]);
        end
      end
    end
  endtask

  task automatic test_width64();
    logic [63:0] va[4];
    logic [63:0] vb[4];
    logic        vc[4];
    logic        vs[4];
    logic [65:0] ve[4];
    va = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0000};
    vb = '{64'h0, 64'h1, 64'h1, 64'h1};
    vc = '{1'b1, 1'b0, 1'b0, 1'b0};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1};
    ve = '{{2'b01, 64'h0}, {2'b10, 64'h8000_0000_0000_0000},
           {2'b00, 64'hFFFF_FFFF_FFFF_FFFF}, {2'b11, 64'h7FFF_FFFF_FFFF_FFFF}};
    out_ready64 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) begin
        in_valid64 = 1'b1; a64 = va[k]; b64 = vb[k]; c064 = vc[k]; sub64 = vs[k];
      end else begin
        in_valid64 = 1'b0;
      end
      #1;
      if (k >= 3) begin
        checks++;
        if (out_valid64 !== 1'b1 || {ovf64, out64} !== ve[k-3]) begin
          errors++; $display("FAIL w64_vec%0d: valid=%b ovf/out=%h expected %h", k - 3, out_valid64, {ovf64, out64}, ve[k-3]);
        end
      end
    end
  endtask

  task automatic test_width_soak();
    int          sent8, got8, sent64, got64, cyc;
    logic [65:0] exp_v;
    sent8 = 0; got8 = 0; sent64 = 0; got64 = 0; cyc = 0;
    q8.delete(); q64.delete();
    while ((got8 < 400 || got64 < 400) && cyc < 4000) begin
      @(negedge clk);
      in_valid8   = (sent8 < 400) && ($urandom_range(0, 3) != 0);
      a8          = 8'($urandom);
      b8          = 8'($urandom);
      c08         = 1'($urandom_range(0, 1));
      sub8        = 1'($urandom_range(0, 1));
      out_ready8  = ($urandom_range(0, 3) != 0);
      in_valid64  = (sent64 < 400) && ($urandom_range(0, 3) != 0);
      a64         = {$urandom, $urandom};
      b64         = {$urandom, $urandom};
      c064        = 1'($urandom_range(0, 1));
      sub64       = 1'($urandom_range(0, 1));
      out_ready64 = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid8 && out_ready8) begin
        checks++;
        exp_v = (q8.size() != 0) ? q8.pop_front() : {66{1'bx}};
        if ({ovf8, out8[8], 56'd0, out8[7:0]} !== exp_v) begin
          errors++; $display("FAIL w8_soak: result %0d got %h expected %h", got8, {ovf8, out8[8], 56'd0, out8[7:0]}, exp_v);
        end
        got8++;
      end
      if (in_valid8 && in_ready8) begin
        q8.push_back(model(8, {56'd0, a8}, {56'd0, b8}, c08, sub8));
        sent8++;
      end
      if (out_valid64 && out_ready64) begin
        checks++;
        exp_v = (q64.size() != 0) ? q64.pop_front() : {66{1'bx}};
        if ({ovf64, out64} !== exp_v) begin
          errors++; $display("FAIL w64_soak: result %0d got %h expected %h", got64, {ovf64, out64}, exp_v);
        end
        got64++;
      end
      if (in_valid64 && in_ready64) begin
        q64.push_back(model(64, a64, b64, c064, sub64));
        sent64++;
      end
      cyc++;
    end
    in_valid8 = 1'b0; in_valid64 = 1'b0; out_ready8 = 1'b1; out_ready64 = 1'b1;
    checks++;
    if (got8 != 400 || got64 != 400 || q8.size() != 0 || q64.size() != 0) begin
      errors++; $display("FAIL width_soak_count: got8=%0d got64=%0d expected 400/400", got8, got64);
    end
  endtask

  task automatic test_soak();
    int          sent, got, cyc;
    logic [65:0] exp_v;
    sent = 0; got = 0; cyc = 0;
    q32.delete();
    while (got < 10000 && cyc < 40000) begin
      @(negedge clk);
      in_valid  = (sent < 10000) && ($urandom_range(0, 4) != 0);
      in1       = $urandom;
      in2       = $urandom;
      c0        = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL soak_in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        exp_v = (q32.size() != 0) ? q32.pop_front() : {66{1'bx}};
        if ({ovf, out[32], 32'd0, out[31:0]} !== exp_v) begin
          errors++; $display("FAIL soak_result: result %0d got %h expected %h", got, {ovf, out[32], 32'd0, out[31:0]}, exp_v);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q32.push_back(model(32, {32'd0, in1}, {32'd0, in2}, c0, sub));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 10000 || q32.size() != 0) begin
      errors++; $display("FAIL soak_count: delivered %0d pending %0d expected 10000/0", got, q32.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_subtract();
    test_reset_midstream();
    test_backpressure();
    test_width8();
    test_width64();
    test_width_soak();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/brent_kung_pipe.md
Name: brent_kung_pipe

Overview:
- Parametrised, pipelined Brent-Kung prefix adder/subtractor; next generation of the 32-bit combinational BrentKung32.
- Adds configurable width, three register stages, valid/ready flow control with backpressure, a subtract mode and a signed-overflow flag.
- Sits between operand-producing logic and result consumers in the datapath; the drop-in for BrentKung32 wherever the adder sits on a clocked path.

Parameters:
- WIDTH, 32, operand width in bits; any power of two from 8 to 64.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- c0  in  1  carry-in (add) / borrow-in (subtract)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- out  out  WIDTH+1  {carry-out, sum}
- ovf  out  1  signed (two's-complement) overflow of the sum

Behaviour:
- Arithmetic:
  - sub=0: out = in1 + in2 + c0.
  - sub=1: out = in1 + ~in2 + !c0, i.e. in1 - in2 - c0. out[WIDTH] is the raw carry (1 = no borrow).
  - ovf = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]), where b' is the possibly inverted in2.
- Carry network: Brent-Kung prefix tree over log2(WIDTH) up-sweep levels and log2(WIDTH)-1 down-sweep levels. Carry-in enters as the generate term at bit -1.
- Stage S1 registers:
  - bitwise g = a&b' and p = a^b';
  - effective carry-in;
  - operand MSBs needed for ovf.
- Stage S2 registers the up-sweep (group g/p) results.
- Stage S3 registers the down-sweep, the sum bits, the carry-out and ovf into out/ovf.
- Latency: exactly 3 clk cycles from an accepted input (in_valid && in_ready) to out_valid, when there is no stall.
- Throughput: one operation per cycle.
- Flow control: single global enable, adv = !out_valid || out_ready.
  - in_ready = adv, purely combinational; no skid buffer.
  - When adv=0, all stages hold their contents; no data is lost or duplicated.
  - Each stage carries a valid bit. Bubbles (in_valid=0 while adv=1) propagate as invalid stages.
- out and ovf are stable while out_valid && !out_ready.
- out and ovf are don't-care when out_valid=0, but the design must drive them from registers.
- Result ordering is strictly FIFO; no reordering.
- Reset (asserted asynchronously, at any time including mid-stall):
  - clears all stage valid bits, out_valid=0, out=0, ovf=0;
  - in-flight operations are discarded.
  - While rst is high, in_ready=1; inputs presented are ignored.
  - First acceptance happens on the first rising clk edge after rst deasserts.
- Width rules: out is exactly WIDTH+1 bits. Carry-out in subtract mode must not be inverted.
- Simultaneous events:
  - An input accepted in the same cycle a result is consumed both take effect; the pipeline shifts.
  - An input offered while out_valid=1 and out_ready=0 is not accepted (in_ready=0).

Test Plan:
- Reset, WIDTH=32: rst pulse mid-stream with 2 ops in flight -> out_valid=0, out=0, ovf=0 immediately, before the next clk edge; no stale results emerge afterwards.
- Latency and carry chain: in1=FFFFFFFF, in2=00000000, c0=1, sub=0, out_ready=1 -> out=1_00000000, ovf=0, out_valid exactly 3 cycles after acceptance.
- Subtract and overflow: in1=80000000, in2=00000001, c0=0, sub=1 -> out=1_7FFFFFFF, ovf=1. Then in1=00000005, in2=00000007, c0=1, sub=1 -> out=0_FFFFFFFD, ovf=0.
- Backpressure: stream 10 back-to-back ops; hold out_ready=0 for cycles 5-8 -> in_ready=0 during the hold; out held stable; all 10 results delivered in order with no drops or duplicates.
- Random soak: 10000 random in1/in2/c0/sub with random out_ready duty -> every result matches a reference model computed as a (WIDTH+1)-bit sum, including ovf.
- Parametrisation: repeat the carry-chain and soak scenarios at WIDTH=8 and WIDTH=64. For WIDTH=8: in1=7F, in2=01, c0=0 -> out=0_80, ovf=1.
